// File: rtl/serve_controller.sv
// serve_controller: captures the selected request, dispatches it over valid/ack, pops the source queue, then cools down.
// Optional request abandonment is compiled in when the TIMEOUT_EN macro is defined.
module serve_controller #(
  parameter int ZONE_W       = 8,
  parameter int PRIO_W       = 2,
  parameter int TIMEOUT_CYC  = 15,
  parameter int COOLDOWN_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              In_Valid,
  input  logic              In_Boost,
  input  logic [PRIO_W-1:0] In_Priority,
  input  logic [ZONE_W-1:0] In_Zone,
  input  logic              In_Select_Shelter,
  input  logic              Unit_Ack,
  output logic              Dispatch_Valid,
  output logic              Dispatch_Boost,
  output logic [PRIO_W-1:0] Dispatch_Priority,
  output logic [ZONE_W-1:0] Dispatch_Zone,
  output logic              Dispatch_Src,
  output logic              Serve_Shelter,
  output logic              Serve_Food,
  output logic              Busy,
  output logic              Timeout_Err,
  output logic [15:0]       Served_Count
);

  typedef enum logic [1:0] {IDLE, REQ, SERVE, COOL} state_e;

  localparam int                COOL_W    = $clog2(COOLDOWN_CYC + 1);
  localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(COOLDOWN_CYC - 1);

  state_e              state_q;
  logic                dispatch_valid_q;
  logic                dispatch_boost_q;
  logic [PRIO_W-1:0]   dispatch_prio_q;
  logic [ZONE_W-1:0]   dispatch_zone_q;
  logic                dispatch_src_q;
  logic                serve_shelter_q;
  logic                serve_food_q;
  logic                busy_q;
  logic                timeout_err_q;
  logic [15:0]         served_count_q;
  logic [COOL_W-1:0]   cool_cnt_q;

`ifdef TIMEOUT_EN
  localparam int               REQ_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [REQ_W-1:0] REQ_LAST = REQ_W'(TIMEOUT_CYC - 1);
  logic [REQ_W-1:0]            req_cnt_q;
`endif

  // NOTE: state lives in one clocked block with non-blocking assignments so every
  // register updates from the same pre-edge values; blocking here would chain them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      dispatch_valid_q <= 1'b0;
      dispatch_boost_q <= 1'b0;
      dispatch_prio_q  <= '0;
      dispatch_zone_q  <= '0;
      dispatch_src_q   <= 1'b0;
      serve_shelter_q  <= 1'b0;
      serve_food_q     <= 1'b0;
      busy_q           <= 1'b0;
      timeout_err_q    <= 1'b0;
      served_count_q   <= '0;
      cool_cnt_q       <= '0;
`ifdef TIMEOUT_EN
      req_cnt_q        <= '0;
`endif
    end else begin
      // Strobes are single-cycle unless a transition below re-asserts them.
      serve_shelter_q <= 1'b0;
      serve_food_q    <= 1'b0;
      timeout_err_q   <= 1'b0;

      case (state_q)
        IDLE: begin
          if (In_Valid) begin
            dispatch_boost_q <= In_Boost;
            dispatch_prio_q  <= In_Priority;
            dispatch_zone_q  <= In_Zone;
            dispatch_src_q   <= In_Select_Shelter;
            dispatch_valid_q <= 1'b1;
            busy_q           <= 1'b1;
            state_q          <= REQ;
`ifdef TIMEOUT_EN
            req_cnt_q        <= '0;
`endif
          end
        end
        REQ: begin
          if (Unit_Ack) begin
            dispatch_valid_q <= 1'b0;
            serve_shelter_q  <= dispatch_src_q;
            serve_food_q     <= ~dispatch_src_q;
            state_q          <= SERVE;
          end
`ifdef TIMEOUT_EN
          // Ack is tested first, so an ack on the expiring cycle still serves.
          else if (req_cnt_q == REQ_LAST) begin
            dispatch_valid_q <= 1'b0;
            busy_q           <= 1'b0;
            timeout_err_q    <= 1'b1;
            state_q          <= IDLE;
          end else begin
            req_cnt_q <= req_cnt_q + 1'b1;
          end
`endif
        end
        SERVE: begin
          if (served_count_q != 16'hFFFF) begin
            served_count_q <= served_count_q + 16'd1;
          end
          cool_cnt_q <= COOL_LOAD;
          state_q    <= COOL;
        end
        COOL: begin
          if (cool_cnt_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cool_cnt_q <= cool_cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Dispatch_Valid    = dispatch_valid_q;
  assign Dispatch_Boost    = dispatch_boost_q;
  assign Dispatch_Priority = dispatch_prio_q;
  assign Dispatch_Zone     = dispatch_zone_q;
  assign Dispatch_Src      = dispatch_src_q;
  assign Serve_Shelter     = serve_shelter_q;
  assign Serve_Food        = serve_food_q;
  assign Busy              = busy_q;
  assign Served_Count      = served_count_q;
`ifdef TIMEOUT_EN
  assign Timeout_Err       = timeout_err_q;
`else
  assign Timeout_Err       = 1'b0;
`endif

endmodule
